// File: rtl/plru_update.sv
// Tree pseudo-LRU controller for a 4-way cache. It reads a set's PLRU state,
// returns the hit or victim way, and writes the updated state back in one pass.
module plru_update #(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [S_INDEX-1:0] req_set,
  input  logic               req_hit,
  input  logic [1:0]         req_way,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [S_INDEX-1:0] resp_set,
  output logic [1:0]         resp_way,
  output logic               lru_csb0,
  output logic               lru_web0,
  output logic [S_INDEX-1:0] lru_addr0,
  input  logic [WIDTH-1:0]   lru_dout0,
  output logic               lru_csb1,
  output logic               lru_web1,
  output logic [S_INDEX-1:0] lru_addr1,
  output logic [WIDTH-1:0]   lru_din1
);

  logic               r_s1Valid;
  logic [S_INDEX-1:0] r_s1Set;
  logic               r_s1Hit;
  logic [1:0]         r_s1Way;
  logic               r_respValid;
  logic [S_INDEX-1:0] r_respSet;
  logic [1:0]         r_respWay;

  logic               w_accept;
  logic               w_s1Adv;
  logic [1:0]         w_victim;
  logic [1:0]         w_way;
  logic [WIDTH-1:0]   w_nextState;

  // Every handshake output is gated by rst_n so reset wins immediately, not one edge later.
  assign w_s1Adv   = rst_n && r_s1Valid && (!r_respValid || resp_ready);
  assign req_ready = rst_n && (!r_s1Valid || w_s1Adv);
  assign w_accept  = req_valid && req_ready;

  assign lru_csb0  = !w_accept;
  assign lru_web0  = 1'b1;
  assign lru_addr0 = req_set;

  assign lru_csb1  = !w_s1Adv;
  assign lru_web1  = !w_s1Adv;
  assign lru_addr1 = r_s1Set;
  assign lru_din1  = w_nextState;

  assign resp_valid = rst_n && r_respValid;
  assign resp_set   = rst_n ? r_respSet : '0;
  assign resp_way   = rst_n ? r_respWay : 2'd0;

  // Bit 0 picks the pair, bits 1/2 pick within the left/right pair; touching a
  // way points every bit on its path away from it and leaves the other pair alone.
  always_comb begin
    w_victim = lru_dout0[0] ? (lru_dout0[2] ? 2'd3 : 2'd2)
                            : (lru_dout0[1] ? 2'd1 : 2'd0);
    w_way = r_s1Hit ? r_s1Way : w_victim;
    w_nextState = lru_dout0;
    w_nextState[0] = ~w_way[1];
    if (!w_way[1]) begin
      w_nextState[1] = ~w_way[0];
    end else begin
      w_nextState[2] = ~w_way[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1Valid   <= 1'b0;
      r_respValid <= 1'b0;
      r_respSet   <= '0;
      r_respWay   <= 2'd0;
      r_s1Set     <= '0;
      r_s1Hit     <= 1'b0;
      r_s1Way     <= 2'd0;
    end else begin
      if (w_accept) begin
        r_s1Valid <= 1'b1;
        r_s1Set   <= req_set;
        r_s1Hit   <= req_hit;
        r_s1Way   <= req_way;
      end else if (w_s1Adv) begin
        r_s1Valid <= 1'b0;
      end

      if (w_s1Adv) begin
        r_respValid <= 1'b1;
        r_respSet   <= r_s1Set;
        r_respWay   <= w_way;
      end else if (r_respValid && resp_ready) begin
        r_respValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_plru_update.sv
// Self-checking bench for plru_update: a behavioural array, a scoreboard with a
// per-set PLRU reference model, directed scenarios and a randomized phase.
module tb_plru_update;

  localparam int SI = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [SI-1:0] req_set;
  logic          req_hit;
  logic [1:0]    req_way;
  logic          resp_valid;
  logic          resp_ready;
  logic [SI-1:0] resp_set;
  logic [1:0]    resp_way;
  logic          lru_csb0, lru_web0, lru_csb1, lru_web1;
  logic [SI-1:0] lru_addr0, lru_addr1;
  logic [2:0]    lru_dout0, lru_din1;

  int checks = 0;
  int errors = 0;

  plru_update #(.S_INDEX(SI), .WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set),
    .req_hit(req_hit), .req_way(req_way),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_set(resp_set), .resp_way(resp_way),
    .lru_csb0(lru_csb0), .lru_web0(lru_web0), .lru_addr0(lru_addr0),
    .lru_dout0(lru_dout0),
    .lru_csb1(lru_csb1), .lru_web1(lru_web1), .lru_addr1(lru_addr1),
    .lru_din1(lru_din1)
  );

  always #5 clk = ~clk;

  // Behavioural PLRU array: registered read address, write lands first so a
  // read captured on the write edge sees the new value.
  logic [2:0]    arrMem [16];
  logic [SI-1:0] arrAddr;
  initial begin
    for (int i = 0; i < 16; i++) arrMem[i] = 3'b000;
    arrAddr = '0;
  end
  always @(posedge clk) begin
    if (!lru_csb1 && !lru_web1) arrMem[lru_addr1] <= lru_din1;
    if (!lru_csb0) arrAddr <= lru_addr0;
  end
  assign lru_dout0 = arrMem[arrAddr];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: per set, which half of the tree is older and which way in
  // each pair is older; victim follows the older pointers, a touch flips them away.
  int olderPair [16];
  int olderLeft [16];
  int olderRight[16];
  initial begin
    for (int i = 0; i < 16; i++) begin
      olderPair[i] = 0; olderLeft[i] = 0; olderRight[i] = 0;
    end
  end

  function automatic int modelVictim(input int s);
    if (olderPair[s] == 0) return olderLeft[s];
    return 2 + olderRight[s];
  endfunction

  function automatic int modelEncode(input int s);
    return olderRight[s] * 4 + olderLeft[s] * 2 + olderPair[s];
  endfunction

  task automatic modelTouch(input int s, input int w);
    olderPair[s] = (w < 2) ? 1 : 0;
    if (w < 2) olderLeft[s] = 1 - (w % 2);
    else       olderRight[s] = 1 - (w % 2);
  endtask

  typedef struct { int set; int hit; int way; } access_t;
  typedef struct { int set; int way; } resp_t;
  access_t pendQ[$];
  resp_t   respQ[$];
  int      logWay[$];
  int      logDin[$];
  int      logWriteCount = 0;

  logic          prevHeld = 1'b0;
  logic [SI-1:0] heldSet;
  logic [1:0]    heldWay;

  // Compare process: every falling edge, check the DUT against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_req_ready", int'(req_ready), 0);
      checkOutput("rst_resp_valid", int'(resp_valid), 0);
      checkOutput("rst_csb0", int'(lru_csb0), 1);
      checkOutput("rst_csb1", int'(lru_csb1), 1);
      checkOutput("rst_web1", int'(lru_web1), 1);
      checkOutput("rst_resp_set", int'(resp_set), 0);
      checkOutput("rst_resp_way", int'(resp_way), 0);
      pendQ.delete();
      respQ.delete();
      prevHeld = 1'b0;
    end else begin
      checkOutput("web0_tied", int'(lru_web0), 1);
      checkOutput("csb1_eq_web1", int'(lru_csb1), int'(lru_web1));
      checkOutput("csb0_accept", int'(lru_csb0), int'(!(req_valid && req_ready)));
      if (req_valid && req_ready) checkOutput("addr0", int'(lru_addr0), int'(req_set));
      if (prevHeld) begin
        checkOutput("held_valid", int'(resp_valid), 1);
        checkOutput("held_set", int'(resp_set), int'(heldSet));
        checkOutput("held_way", int'(resp_way), int'(heldWay));
      end
      if (!lru_csb1) begin
        if (pendQ.size() == 0) begin
          checkOutput("unexpected_write", 1, 0);
        end else begin
          access_t a;
          resp_t r;
          int w;
          a = pendQ.pop_front();
          w = a.hit ? a.way : modelVictim(a.set);
          modelTouch(a.set, w);
          checkOutput("write_addr", int'(lru_addr1), a.set);
          checkOutput("write_data", int'(lru_din1), modelEncode(a.set));
          logDin.push_back(int'(lru_din1));
          logWriteCount++;
          r.set = a.set;
          r.way = w;
          respQ.push_back(r);
        end
      end
      if (resp_valid && resp_ready) begin
        if (respQ.size() == 0) begin
          checkOutput("unexpected_resp", 1, 0);
        end else begin
          resp_t r;
          r = respQ.pop_front();
          checkOutput("resp_set", int'(resp_set), r.set);
          checkOutput("resp_way", int'(resp_way), r.way);
          logWay.push_back(int'(resp_way));
        end
      end
      if (req_valid && req_ready) begin
        access_t a;
        a.set = int'(req_set);
        a.hit = int'(req_hit);
        a.way = int'(req_way);
        pendQ.push_back(a);
      end
      prevHeld = resp_valid && !resp_ready;
      heldSet  = resp_set;
      heldWay  = resp_way;
    end
  end

  task automatic applyStimulus(input int s, input bit h, input int w);
    int budget;
    req_valid = 1'b1;
    req_set   = SI'(s);
    req_hit   = h;
    req_way   = 2'(w);
    budget = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      budget++;
      if (budget > 50) begin
        checkOutput("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    logWay.delete();
    logDin.delete();
    logWriteCount = 0;
  endtask

  task automatic expectLogs(input string name, input int ways[4], input int dins[4], input int n);
    checkOutput({name, "_resp_count"}, logWay.size(), n);
    checkOutput({name, "_write_count"}, logDin.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < logWay.size()) checkOutput({name, "_way"}, logWay[i], ways[i]);
      if (i < logDin.size()) checkOutput({name, "_din"}, logDin[i], dins[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_set = '0; req_hit = 1'b0; req_way = 2'd0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_req_ready", int'(req_ready), 1);
    checkOutput("post_reset_resp_valid", int'(resp_valid), 0);
    @(posedge clk); #1;

    // Miss sequence on set 3, back to back.
    clearLogs();
    for (int i = 0; i < 4; i++) applyStimulus(3, 1'b0, 0);
    idle(3);
    expectLogs("miss_seq", '{0, 2, 1, 3}, '{3, 6, 5, 0}, 4);

    // Hit way 2 on set 5, then miss on set 5.
    clearLogs();
    applyStimulus(5, 1'b1, 2);
    applyStimulus(5, 1'b0, 0);
    idle(3);
    expectLogs("hit_miss", '{2, 0, 0, 0}, '{4, 7, 0, 0}, 2);

    // Backpressure: three requests to set 6 with resp_ready low.
    clearLogs();
    resp_ready = 1'b0;
    fork
      begin
        applyStimulus(6, 1'b0, 0);
        applyStimulus(6, 1'b0, 0);
        applyStimulus(6, 1'b0, 0);
      end
      begin
        repeat (5) @(negedge clk);
        checkOutput("bp_req_ready_low", int'(req_ready), 0);
        checkOutput("bp_resp_valid", int'(resp_valid), 1);
        checkOutput("bp_writes_while_stalled", logWriteCount, 1);
        @(posedge clk); #1;
        resp_ready = 1'b1;
      end
    join
    idle(4);
    expectLogs("backpressure", '{0, 2, 1, 0}, '{3, 6, 5, 0}, 3);

    // Interleaved misses on sets 0 and 15.
    clearLogs();
    for (int i = 0; i < 8; i++) applyStimulus((i % 2 == 0) ? 0 : 15, 1'b0, 0);
    idle(3);
    checkOutput("interleave_count", logWay.size(), 8);
    for (int i = 0; i < 8 && i < logWay.size(); i++) begin
      int expWays[4];
      expWays = '{0, 2, 1, 3};
      checkOutput("interleave_way", logWay[i], expWays[i / 2]);
    end

    // Reset with s1 and the response register both occupied.
    clearLogs();
    resp_ready = 1'b0;
    applyStimulus(10, 1'b0, 0);
    applyStimulus(11, 1'b0, 0);
    rst_n = 1'b0;
    idle(2);
    checkOutput("reset_mid_writes", logWriteCount, 1);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("reset_mid_req_ready", int'(req_ready), 1);
    @(posedge clk); #1;
    clearLogs();
    applyStimulus(9, 1'b0, 0);
    idle(3);
    checkOutput("fresh_set_count", logWay.size(), 1);
    if (logWay.size() > 0) checkOutput("fresh_set_victim", logWay[0], 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_set    = SI'($urandom_range(0, 15));
      req_hit    = $urandom_range(0, 1);
      req_way    = 2'($urandom_range(0, 3));
      resp_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    idle(5);
    checkOutput("drain_pending", pendQ.size(), 0);
    checkOutput("drain_resp", respQ.size(), 0);
    checkOutput("drain_resp_valid", int'(resp_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
